// File: rtl/rgb_breather_pkg.sv
// Shared encodings and helpers for the RGB breathing LED stage.
package rgb_breather_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_BREATHE = 2'b01,
    MODE_SOLID   = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RISE  = 2'b01,
    FALL  = 2'b10,
    SOLID = 2'b11
  } state_e;

  // Prescaler counter width; never narrower than one bit.
  function automatic int presc_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/rgb_breather_if.sv
// Control inputs and LED/monitor outputs of the breathing LED stage.
interface rgb_breather_if;
  logic       enable;
  logic [1:0] mode;
  logic [2:0] color;
  logic       led_red;
  logic       led_green;
  logic       led_blue;
  logic       gpio_2;

  modport master (
    output enable, mode, color,
    input  led_red, led_green, led_blue, gpio_2
  );

  modport slave (
    input  enable, mode, color,
    output led_red, led_green, led_blue, gpio_2
  );
endinterface

// File: rtl/rgb_breather_tick.sv
// Enable-gated prescaler emitting a tick once every STEP_CYCLES enabled clocks.
module tick_gen
  import rgb_breather_pkg::*;
#(
  parameter int STEP_CYCLES = 93750
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  output logic tick_o
);

  localparam int W = presc_width(STEP_CYCLES);
  localparam logic [W-1:0] LAST = W'(STEP_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_last;

  assign at_last = (cnt_q == LAST);
  assign tick_o  = enable_i && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (enable_i) begin
      cnt_d = at_last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgb_breather.sv
// Triangle/solid brightness generator driving glitch-free PWM on the RGB LEDs.
module rgb_breather
  import rgb_breather_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 93750
) (
  input  logic           clk,
  input  logic           rst,
  rgb_breather_if.slave  io
);

  localparam logic [PWM_BITS-1:0] DMAX = '1;
  localparam logic [PWM_BITS-1:0] ONE  = PWM_BITS'(1);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_live_q;
  state_e              state_q;
  logic                gpio_q;
  logic [2:0]          led_q;
  logic [2:0]          led_d;
  logic                step_tick;
  logic                period_end;
  logic                mode_off;

  tick_gen #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .enable_i (io.enable),
    .tick_o   (step_tick)
  );

  assign period_end = (pwm_cnt_q == DMAX);
  assign mode_off   = (io.mode == MODE_OFF) || (io.mode == MODE_RSVD);

  always_comb begin
    pwm_cnt_d = io.enable ? pwm_cnt_q + ONE : pwm_cnt_q;
    led_d     = {3{io.enable}} & io.color & {3{pwm_cnt_q < duty_live_q}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  // Mode changes act immediately; only the ramp itself waits for step_tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      duty_q      <= '0;
      duty_live_q <= '0;
      gpio_q      <= 1'b0;
    end else begin
      gpio_q <= 1'b0;
      if (io.enable) begin
        case (io.mode)
          MODE_SOLID: begin
            state_q <= SOLID;
            duty_q  <= DMAX;
          end
          MODE_BREATHE: begin
            case (state_q)
              IDLE, SOLID: begin
                state_q <= RISE;
                duty_q  <= '0;
              end
              RISE: begin
                if (step_tick) begin
                  if (duty_q == DMAX) state_q <= FALL;
                  else                duty_q  <= duty_q + ONE;
                end
              end
              FALL: begin
                if (step_tick) begin
                  if (duty_q == '0) begin
                    state_q <= RISE;
                    gpio_q  <= 1'b1;
                  end else begin
                    duty_q <= duty_q - ONE;
                  end
                end
              end
              default: state_q <= IDLE;
            endcase
          end
          default: begin
            state_q <= IDLE;
            duty_q  <= '0;
          end
        endcase

        // Duty is only latched at the period boundary so a period never changes width.
        if (mode_off)        duty_live_q <= '0;
        else if (period_end) duty_live_q <= duty_q;
      end
    end
  end

  assign io.led_red   = led_q[2];
  assign io.led_green = led_q[1];
  assign io.led_blue  = led_q[0];
  assign io.gpio_2    = gpio_q;

endmodule

// File: tb/tb_rgb_breather.sv
// Directed plus randomized check of rgb_breather against a cycle-level behavioural model.
module tb_rgb_breather;
  import rgb_breather_pkg::*;

  localparam int PB   = 4;
  localparam int SC   = 2;
  localparam int DMAX = (1 << PB) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb_breather_if bus ();

  rgb_breather #(.PWM_BITS(PB), .STEP_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int     m_pwm, m_presc, m_duty, m_live;
  state_e m_st;
  bit [2:0] m_led;
  bit     m_gpio;

  int p_hi, p_live;
  bit p_gap, p_seen_low, p_clean, p_started;

  int gpio_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(output int op, output int live_pre, output bit clean_cyc);
    int  od;
    bit  tick, pe, off;
    od        = m_duty;
    op        = m_pwm;
    live_pre  = m_live;
    off       = (bus.mode == 2'b00) || (bus.mode == 2'b11);
    clean_cyc = !rst && bus.enable && bus.color[2] && !off;
    if (rst) begin
      m_pwm = 0; m_presc = 0; m_duty = 0; m_live = 0;
      m_st = IDLE; m_led = 3'b000; m_gpio = 1'b0;
      return;
    end
    tick   = (m_presc == SC - 1);
    pe     = (m_pwm == DMAX);
    m_led  = bus.enable ? (bus.color & {3{op < m_live}}) : 3'b000;
    m_gpio = 1'b0;
    if (bus.enable) begin
      m_pwm   = (m_pwm + 1) % (DMAX + 1);
      m_presc = tick ? 0 : m_presc + 1;
      if (bus.mode == 2'b10) begin
        m_st = SOLID; m_duty = DMAX;
      end else if (bus.mode == 2'b01) begin
        if (m_st == IDLE || m_st == SOLID) begin
          m_st = RISE; m_duty = 0;
        end else if (tick && m_st == RISE) begin
          if (od == DMAX) m_st = FALL;
          else            m_duty = od + 1;
        end else if (tick && m_st == FALL) begin
          if (od == 0) begin m_st = RISE; m_gpio = 1'b1; end
          else         m_duty = od - 1;
        end
      end else begin
        m_st = IDLE; m_duty = 0;
      end
      if (off)     m_live = 0;
      else if (pe) m_live = od;
    end
  endtask

  task automatic step();
    int op, live_pre;
    bit clean_cyc;
    @(posedge clk);
    model_edge(op, live_pre, clean_cyc);
    #1;
    check("led_red",   bus.led_red,   m_led[2]);
    check("led_green", bus.led_green, m_led[1]);
    check("led_blue",  bus.led_blue,  m_led[0]);
    check("gpio_2",    bus.gpio_2,    m_gpio);
    check("duty",      dut.duty_q,    m_duty);
    check("pwm_cnt",   dut.pwm_cnt_q, m_pwm);
    check("state",     32'(dut.state_q), 32'(m_st));
    if (bus.gpio_2 === 1'b1) gpio_seen++;
    // Per-period red waveform: high count equals the latched duty, contiguous from count 0.
    if (op == 0) begin
      p_hi = 0; p_gap = 0; p_seen_low = 0; p_clean = 1; p_started = 1; p_live = live_pre;
    end
    if (!clean_cyc || live_pre != p_live) p_clean = 0;
    if (bus.led_red === 1'b1) begin
      if (p_seen_low) p_gap = 1;
      p_hi++;
    end else begin
      p_seen_low = 1;
    end
    if (op == DMAX && p_started && p_clean) begin
      check("period_high", p_hi, p_live);
      check("period_contig", p_gap, 0);
      p_started = 0;
    end
  endtask

  task automatic run_until(input int d, input state_e s, input int maxc, input string tag);
    bit found = 0;
    for (int i = 0; i < maxc && !found; i++) begin
      step();
      if (m_duty == d && m_st == s) found = 1;
    end
    check(tag, found, 1);
  endtask

  initial begin
    int hc, first_g, d0, p0, seg;
    m_pwm = 0; m_presc = 0; m_duty = 0; m_live = 0; m_st = IDLE;
    m_led = 0; m_gpio = 0; p_clean = 0; p_started = 0; gpio_seen = 0;
    p_hi = 0; p_live = 0; p_gap = 0; p_seen_low = 0;
    rst = 1'b1; bus.enable = 1'b0; bus.mode = 2'b00; bus.color = 3'b000;

    repeat (3) step();
    check("rst_leds", {bus.led_red, bus.led_green, bus.led_blue, bus.gpio_2}, 0);

    // Breathe from reset: dark first period, one completion pulse near clock 62.
    rst = 1'b0; bus.enable = 1'b1; bus.mode = 2'b01; bus.color = 3'b111;
    hc = 0; first_g = -1; gpio_seen = 0;
    for (int i = 1; i <= 70; i++) begin
      step();
      if (i <= 16) hc += int'(bus.led_red) + int'(bus.led_green) + int'(bus.led_blue);
      if (bus.gpio_2 === 1'b1 && first_g < 0) first_g = i;
    end
    check("first16_dark", hc, 0);
    check("gpio_count", gpio_seen, 1);
    check("gpio_time", (first_g >= 60 && first_g <= 66), 1);

    // Solid red.
    bus.mode = 2'b10; bus.color = 3'b100;
    repeat (40) step();
    hc = 0;
    repeat (16) begin step(); hc += int'(bus.led_red); end
    check("solid_red_15of16", hc, 15);

    // Mid-ramp off, then restart.
    bus.mode = 2'b01; bus.color = 3'b111;
    run_until(7, RISE, 60, "reach_duty7");
    bus.mode = 2'b00;
    step(); step();
    check("off_dark", {bus.led_red, bus.led_green, bus.led_blue}, 0);
    check("off_duty", dut.duty_q, 0);
    bus.mode = 2'b01;
    step();
    check("restart_state", 32'(dut.state_q), 32'(RISE));
    check("restart_duty", dut.duty_q, 0);

    // Hold with enable low.
    run_until(9, RISE, 60, "reach_duty9");
    d0 = m_duty; p0 = m_pwm; gpio_seen = 0;
    bus.enable = 1'b0;
    repeat (40) step();
    check("hold_duty", dut.duty_q, d0);
    check("hold_pwm", dut.pwm_cnt_q, p0);
    check("hold_dark", {bus.led_red, bus.led_green, bus.led_blue}, 0);
    bus.enable = 1'b1;
    repeat (10) step();
    check("resume_no_gpio", gpio_seen, 0);

    // Reset at full scale while falling.
    run_until(DMAX, FALL, 200, "reach_fall_max");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_outs", {bus.led_red, bus.led_green, bus.led_blue, bus.gpio_2}, 0);
    check("rst_mid_duty", dut.duty_q, 0);
    check("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_mid_pwm", dut.pwm_cnt_q, 0);

    // Randomized mode/colour/enable/reset activity.
    for (int k = 0; k < 40; k++) begin
      bus.mode   = 2'($urandom_range(0, 3));
      bus.color  = 3'($urandom_range(0, 7));
      bus.enable = ($urandom_range(0, 7) != 0);
      rst        = ($urandom_range(0, 19) == 0);
      seg        = $urandom_range(1, 40);
      step();
      rst = 1'b0;
      repeat (seg) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
